// File: rtl/gumnut_arb_pkg.sv
// Shared types and constants for the two-master Gumnut data-bus arbiter.
package gumnut_arb_pkg;

  localparam int unsigned NUM_M  = 2;
  localparam int unsigned M_CORE = 0;
  localparam int unsigned M_AUX  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Ownership state for a given master index.
  function automatic arb_state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

  // One-hot grant vector for a state; zero when idle.
  function automatic logic [NUM_M-1:0] grant_of(input arb_state_e st);
    logic [NUM_M-1:0] g;
    g = '0;
    if (st == OWN0) g[M_CORE] = 1'b1;
    if (st == OWN1) g[M_AUX]  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/gumnut_arb_pick.sv
// Combinational winner select: lone requester wins; on a tie the master that
// was not granted last time wins.
module gumnut_arb_pick
  import gumnut_arb_pkg::*;
(
  input  logic [NUM_M-1:0] req_i,
  input  logic             last_i,
  output logic             win_vld_c,
  output logic             win_idx_c
);

  always_comb begin
    win_vld_c = |req_i;
    win_idx_c = 1'(M_CORE);
    case (req_i)
      2'b10:   win_idx_c = 1'(M_AUX);
      2'b11:   win_idx_c = ~last_i;
      default: win_idx_c = 1'(M_CORE);
    endcase
  end

endmodule

// File: rtl/gumnut_data_arbiter.sv
// Two-master arbiter for the Gumnut 8-bit data memory bus (cyc/stb/we/ack).
// Define GUMNUT_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed
// priority with master 0 winning every tie.
module gumnut_data_arbiter
  import gumnut_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_M*DATA_W-1:0] m_dat_i,
  output logic [DATA_W-1:0]       m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_W-1:0]       s_adr_o,
  output logic [DATA_W-1:0]       s_dat_o,
  input  logic [DATA_W-1:0]       s_dat_i,
  input  logic                    s_ack_i,
  output logic [NUM_M-1:0]        grant_o
);

  arb_state_e       state_d, state_q;
  logic [NUM_M-1:0] pick_req;
  logic             win_vld;
  logic             win_idx;
  logic             last_c;

  // The current owner is excluded so that release can only hand over.
  always_comb begin
    pick_req = m_cyc_i;
    case (state_q)
      OWN0:    pick_req[M_CORE] = 1'b0;
      OWN1:    pick_req[M_AUX]  = 1'b0;
      default: ;
    endcase
  end

  gumnut_arb_pick u_pick (
    .req_i     (pick_req),
    .last_i    (last_c),
    .win_vld_c (win_vld),
    .win_idx_c (win_idx)
  );

  // Ownership holds while the owner keeps cyc high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = own_state(win_idx);
      OWN0:    if (!m_cyc_i[M_CORE]) state_d = win_vld ? OWN1 : IDLE;
      OWN1:    if (!m_cyc_i[M_AUX])  state_d = win_vld ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

`ifdef GUMNUT_ARB_ROUND_ROBIN_EN
  logic last_d, last_q;

  // Remember who was granted most recently; resets as if master 1 went last.
  always_comb begin
    last_d = last_q;
    if ((state_d != state_q) && (state_d != IDLE)) last_d = win_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'(M_AUX);
    else       last_q <= last_d;
  end

  assign last_c = last_q;
`else
  assign last_c = 1'(M_AUX);
`endif

  // Data path follows the registered owner; idle drives zeros.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    case (state_q)
      OWN0: begin
        s_cyc_o         = m_cyc_i[M_CORE];
        s_stb_o         = m_stb_i[M_CORE];
        s_we_o          = m_we_i[M_CORE];
        s_adr_o         = m_adr_i[M_CORE*ADDR_W +: ADDR_W];
        s_dat_o         = m_dat_i[M_CORE*DATA_W +: DATA_W];
        m_ack_o[M_CORE] = s_ack_i;
      end
      OWN1: begin
        s_cyc_o        = m_cyc_i[M_AUX];
        s_stb_o        = m_stb_i[M_AUX];
        s_we_o         = m_we_i[M_AUX];
        s_adr_o        = m_adr_i[M_AUX*ADDR_W +: ADDR_W];
        s_dat_o        = m_dat_i[M_AUX*DATA_W +: DATA_W];
        m_ack_o[M_AUX] = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_of(state_q);

endmodule

// File: tb/tb_gumnut_data_arbiter.sv
// Self-checking bench for gumnut_data_arbiter: an owner/priority model checked
// on every falling edge, plus directed literal checks.
module tb_gumnut_data_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [2*AW-1:0] m_adr_i;
  logic [2*DW-1:0] m_dat_i;
  logic [DW-1:0] m_dat_o;
  logic [1:0]    m_ack_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [1:0]    grant_o;

  int checks = 0;
  int errors = 0;

  gumnut_data_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (none), 0 or 1; last is the most recently granted master.
  int own  = -1;
  int last = 1;

  function automatic int tie_winner(input int prev);
`ifdef GUMNUT_ARB_ROUND_ROBIN_EN
    return 1 - prev;
`else
    return (prev < 0) ? 0 : 0;
`endif
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    int cand;
    if (rst_i) begin
      own  = -1;
      last = 1;
    end else if (own < 0 || !m_cyc_i[own]) begin
      cand = int'(m_cyc_i);
      if (own >= 0) cand = cand & ~(1 << own);
      case (cand)
        0:       own = -1;
        1:       own = 0;
        2:       own = 1;
        default: own = tie_winner(last);
      endcase
      if (own >= 0) last = own;
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk_i) begin
    logic [1:0]    e_gnt, e_ack;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    e_gnt = 2'b00; e_ack = 2'b00;
    e_cyc = 1'b0;  e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0;    e_dat = '0;
    if (own == 0) begin
      e_gnt = 2'b01; e_cyc = m_cyc_i[0]; e_stb = m_stb_i[0]; e_we = m_we_i[0];
      e_adr = m_adr_i[7:0]; e_dat = m_dat_i[7:0]; e_ack = {1'b0, s_ack_i};
    end else if (own == 1) begin
      e_gnt = 2'b10; e_cyc = m_cyc_i[1]; e_stb = m_stb_i[1]; e_we = m_we_i[1];
      e_adr = m_adr_i[15:8]; e_dat = m_dat_i[15:8]; e_ack = {s_ack_i, 1'b0};
    end
    chk("model_grant", 32'(grant_o), 32'(e_gnt));
    chk("model_ack",   32'(m_ack_o), 32'(e_ack));
    chk("model_slave", 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}),
        32'({e_cyc, e_stb, e_we, e_adr, e_dat}));
    chk("model_rdata", 32'(m_dat_o), 32'(s_dat_i));
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_i   = 1'b1;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    m_we_i  = 2'b00;
    m_adr_i = {8'h40, 8'h10};
    m_dat_i = {8'h77, 8'h5A};
    s_dat_i = 8'h00;
    s_ack_i = 1'b0;

    // Reset with both masters requesting.
    #12;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_cyc",   32'(s_cyc_o), 32'h0);
    chk("rst_ack",   32'(m_ack_o), 32'h0);
    chk("rst_adr",   32'(s_adr_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    next_cycle();
    chk("first_grant", 32'(grant_o), 32'h1);
    chk("first_adr",   32'(s_adr_o), 32'h10);
    chk("first_cyc",   32'(s_cyc_o), 32'h1);

    // m0 burst of three zero-wait beats while m1 waits.
    s_ack_i = 1'b1;
    #1 chk("beat0_ack", 32'(m_ack_o), 32'h1);
    next_cycle();
    m_adr_i[7:0] = 8'h11;
    #1 chk("beat1_adr", 32'(s_adr_o), 32'h11);
    chk("beat1_ack", 32'(m_ack_o), 32'h1);
    next_cycle();
    m_adr_i[7:0] = 8'h12;
    #1 chk("beat2_ack", 32'(m_ack_o), 32'h1);
    next_cycle();
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; s_ack_i = 1'b0;
    #1 chk("release_grant", 32'(grant_o), 32'h1);
    next_cycle();
    chk("handover_grant", 32'(grant_o), 32'h2);
    chk("handover_adr",   32'(s_adr_o), 32'h40);

    // m1 read with two wait states.
    s_dat_i = 8'hA5;
    #1 chk("wait1_ack", 32'(m_ack_o), 32'h0);
    next_cycle();
    chk("wait2_ack", 32'(m_ack_o), 32'h0);
    next_cycle();
    s_ack_i = 1'b1;
    #1 chk("read_ack",  32'(m_ack_o), 32'h2);
    chk("read_data", 32'(m_dat_o), 32'hA5);
    next_cycle();
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; s_ack_i = 1'b0;
    next_cycle();

    // Spurious slave ack while idle.
    s_ack_i = 1'b1;
    #1 chk("idle_ack",   32'(m_ack_o), 32'h0);
    chk("idle_grant", 32'(grant_o), 32'h0);

    // Repeated ties from idle.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      s_ack_i = 1'b0;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      m_adr_i = {8'(8'h80 + i), 8'(8'h20 + i)};
      next_cycle();
`ifdef GUMNUT_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      chk("tie_grant", 32'(grant_o), 32'(exp_g));
      s_ack_i = 1'b1;
      next_cycle();
      m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b0;
    end

    // Reset pulsed during an m1 write.
    next_cycle();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i = {8'h55, 8'h00}; m_dat_i = {8'h3C, 8'h00};
    next_cycle();
    #1 chk("wr_grant", 32'(grant_o), 32'h2);
    chk("wr_we",  32'(s_we_o),  32'h1);
    chk("wr_dat", 32'(s_dat_o), 32'h3C);
    s_ack_i = 1'b1;
    #1 rst_i = 1'b1;
    #1 chk("async_cyc", 32'(s_cyc_o), 32'h0);
    chk("async_we",  32'(s_we_o),  32'h0);
    chk("async_ack", 32'(m_ack_o), 32'h0);
    s_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("post_rst_grant", 32'(grant_o), 32'h0);
    next_cycle();
    chk("regrant_m1", 32'(grant_o), 32'h2);
    m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
